gamma_loader: RTL
=================

# gamma_loader

Controller that sequences writes into the video mixer's gamma correction table and owns its enable bit. It sits between the host download path (byte stream) and the mixer's 22-bit `gamma_bus`. It fills the 768-entry table (R, G, B × 256) from a ready/valid byte stream, gated to vertical blanking to avoid mid-frame tearing. It switches `gamma_en` only at a frame boundary and only once a complete table has been loaded.

## Interface
Parameters:
- `ENTRIES`, 768, number of table bytes per load (≤ 1024, addresses 0..ENTRIES-1).
- `VBL_GATE`, 1, 1 = accept and write bytes only while VBlank is high; 0 = write any time.

Ports:
- `clk_sys`  in  1  system clock; also driven onto `gamma_bus[20]`.
- `reset`  in  1  asynchronous, active-high reset.
- `vblank`  in  1  VBlank from video domain (asynchronous to `clk_sys`; 2-FF synchronised inside).
- `gamma_en_req`  in  1  requested gamma enable level.
- `load_start`  in  1  single-cycle pulse; begins (or restarts) a table load at address 0.
- `din_valid`  in  1  byte-stream valid.
- `din`  in  8  table byte, in address order.
- `din_ready`  out  1  byte-stream ready; transfer occurs when `din_valid & din_ready`.
- `busy`  out  1  high in WAIT_VBL or LOAD.
- `load_done`  out  1  one-cycle pulse when the last byte of a load is accepted.
- `table_valid`  out  1  a complete table has been written since reset.
- `gamma_bus`  inout  22  [21] in: mixer reports gamma present; [20] out `clk_sys`; [19] out `gamma_en`; [18] out `gamma_wr`; [17:8] out `gamma_wr_addr`; [7:0] out `gamma_value`.

## Operation
- Sync chain: `vbl_s` is the second flop of `vblank`; `vbl_rise` = `vbl_s & ~vbl_s_d`.
- The FSM has three states: IDLE, WAIT_VBL, LOAD.
- IDLE, on `load_start`:
  - `VBL_GATE=1`: go to WAIT_VBL.
  - `VBL_GATE=0`: go to LOAD.
  - In both cases `cnt` is set to 0.
- WAIT_VBL: on `vbl_rise`, go to LOAD. A load never starts in the middle of a blanking interval.
- LOAD:
  - `din_ready = vbl_s | ~VBL_GATE`.
  - When `vbl_s` falls, `din_ready` drops and the FSM stays in LOAD, paused. It resumes on the next high `vbl_s`, with no need for a new rising edge.
  - Each transfer registers `gamma_wr_addr = cnt`, `gamma_value = din` and `gamma_wr = 1` for one cycle, then increments `cnt`.
  - Transfer at `cnt == ENTRIES-1`: pulse `load_done`, set `table_valid` (only if `gamma_bus[21]`), go to IDLE.
- `din_ready` is 0 in IDLE and in WAIT_VBL. `din_valid` is ignored there.
- `load_start` while in WAIT_VBL or LOAD:
  - Restarts at `cnt = 0`.
  - With `VBL_GATE=1` it returns to WAIT_VBL; with `VBL_GATE=0` it stays in LOAD.
  - It has priority over a coincident transfer: that byte is not written and `load_done` does not pulse.
- Starting a new load clears `table_valid` and forces `gamma_en` to 0 immediately. The table is then partially stale.
- Enable: on each `vbl_rise`, `gamma_en <= gamma_en_req & table_valid`. Between edges `gamma_en` holds, except that it is forced to 0 by a load start.
- No gamma present (`gamma_bus[21] == 0`):
  - `gamma_wr` and `gamma_en` are held at 0.
  - Bytes are still accepted and counted, and `load_done` still pulses, so the host never stalls.
  - `table_valid` stays 0.

## Timing
- Reset values:
  - FSM = IDLE, `cnt` = 0.
  - `din_ready`, `busy`, `load_done`, `table_valid` = 0.
  - `gamma_en`, `gamma_wr`, `gamma_wr_addr`, `gamma_value` = 0.
  - Sync flops = 0.
- Reset asserted mid-load: the load is abandoned and all of the above reset values apply.
- Latencies:
  - `vblank` edge to `vbl_s` edge: 2 cycles. `vbl_rise` is visible in cycle 3 and `gamma_en` updates in cycle 4.
  - A transfer in cycle N appears as `gamma_wr` with its addr/value in cycle N+1.
  - `load_done` is registered and asserted in cycle N+1 of the last transfer.
- `busy` is registered from the next state. It rises the cycle after `load_start` and falls the cycle after the last transfer.
- Maximum throughput is one byte per cycle while `din_ready` is high. A full load with continuous valid in a long VBlank takes `ENTRIES` cycles.
- `gamma_bus[20]` is a combinational pass-through of `clk_sys`. All other outputs are flop-driven.

## Test plan
- Gated full load:
  - Stimulus: `gamma_bus[21]=1`, `load_start`, `vblank` held high, then 768 bytes with `din[i]=i[7:0]`, continuous valid.
  - Required response: `gamma_wr` pulses 768 times at addr 0..767 with matching values; `load_done` pulses once with the last write; `table_valid=1`.
- Blank-boundary pause:
  - Stimulus: `vblank` falls after 300 transfers.
  - Required response: `din_ready` drops 2–3 cycles later; no writes occur while `vbl_s=0`; the load resumes at addr 300 on the next VBlank; 768 writes total with no duplicates.
- Enable gating:
  - Stimulus: `gamma_en_req=1` before any load.
  - Required response: `gamma_en` stays 0 across VBlank edges. After a completed load, `gamma_en` goes to 1 exactly 4 cycles after the next `vblank` rising edge and not before.
- Restart:
  - Stimulus: `load_start` mid-load at `cnt=500`, coincident with a valid byte.
  - Required response: that byte is not written; `gamma_en` and `table_valid` go to 0; the next write is addr 0 after the following `vbl_rise`; no `load_done` from the aborted load.
- No gamma:
  - Stimulus: `gamma_bus[21]=0`, full 768-byte load.
  - Required response: all bytes are accepted; `gamma_wr` is never asserted; `load_done` pulses; `table_valid` and `gamma_en` remain 0.
- Async reset:
  - Stimulus: `reset` pulse at `cnt=100`.
  - Required response: all outputs return to 0 immediately (asynchronously); the FSM is IDLE; `din_ready=0` until the next `load_start`.

Source files
------------

// File: rtl/gamma_loader.sv
// gamma_loader
//   Sequences host bytes into the mixer's 768-entry gamma table and owns the
//   gamma enable bit. Writes are gated to vertical blanking (VBL_GATE=1) so the
//   table never changes mid-frame. The enable only changes on a VBlank rising
//   edge, and only once a complete table has been loaded.
//
// Ports
//   clk_sys       system clock (also forwarded on gamma_bus[20])
//   reset         asynchronous, active-high reset
//   vblank        VBlank from the video domain, asynchronous, synchronised here
//   gamma_en_req  requested enable level, sampled on each VBlank rising edge
//   load_start    one-cycle pulse: start or restart a load at address 0
//   din_valid/din/din_ready  ready/valid byte stream, bytes in address order
//   busy          a load is pending (waiting for VBlank) or in progress
//   load_done     one-cycle pulse, registered with the last byte's write
//   table_valid   a complete table has been written and not since invalidated
//   gamma_bus     [21] in gamma present, [20] clk, [19] enable, [18] write,
//                 [17:8] write address, [7:0] write value
module gamma_loader #(
  parameter int ENTRIES  = 768,
  parameter bit VBL_GATE = 1'b1
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        vblank,
  input  logic        gamma_en_req,
  input  logic        load_start,
  input  logic        din_valid,
  input  logic [7:0]  din,
  output logic        din_ready,
  output logic        busy,
  output logic        load_done,
  output logic        table_valid,
  inout  wire  [21:0] gamma_bus
);

  localparam logic [9:0] CNT_LAST = 10'(ENTRIES - 1);

  typedef enum logic [1:0] {IDLE, WAIT_VBL, LOAD} state_t;

  state_t     state, state_nx;
  logic [9:0] cnt;
  logic       vbl_m, vbl_s, vbl_s_d;
  logic       vbl_rise;
  logic       present;
  logic       xfer, last;
  logic       ready_nx;
  logic       gamma_en, gamma_wr;
  logic [9:0] wr_addr;
  logic [7:0] wr_value;

  assign present  = gamma_bus[21];
  assign vbl_rise = vbl_s & ~vbl_s_d;

  assign gamma_bus[20]   = clk_sys;
  assign gamma_bus[19]   = gamma_en;
  assign gamma_bus[18]   = gamma_wr;
  assign gamma_bus[17:8] = wr_addr;
  assign gamma_bus[7:0]  = wr_value;

  // A coincident load_start wins over a byte transfer: the byte is dropped.
  always_comb begin
    state_nx = state;
    xfer     = (state == LOAD) & din_valid & din_ready & ~load_start;
    last     = xfer & (cnt == CNT_LAST);
    case (state)
      IDLE:     state_nx = IDLE;
      WAIT_VBL: if (vbl_rise) state_nx = LOAD;
      LOAD:     if (last)     state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
    if (load_start) state_nx = VBL_GATE ? WAIT_VBL : LOAD;
    // din_ready is registered, so look one flop ahead on the sync chain:
    // vbl_m is what vbl_s will hold next cycle. This keeps din_ready equal to
    // (state==LOAD) & (vbl_s | ~VBL_GATE) while still coming from a flop.
    ready_nx = (state_nx == LOAD) & (vbl_m | ~VBL_GATE);
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      vbl_m       <= 1'b0;
      vbl_s       <= 1'b0;
      vbl_s_d     <= 1'b0;
      state       <= IDLE;
      cnt         <= '0;
      din_ready   <= 1'b0;
      busy        <= 1'b0;
      load_done   <= 1'b0;
      table_valid <= 1'b0;
      gamma_en    <= 1'b0;
      gamma_wr    <= 1'b0;
      wr_addr     <= '0;
      wr_value    <= '0;
    end else begin
      vbl_m     <= vblank;
      vbl_s     <= vbl_m;
      vbl_s_d   <= vbl_s;
      state     <= state_nx;
      din_ready <= ready_nx;
      busy      <= (state_nx != IDLE);
      load_done <= last;

      if (load_start)  cnt <= '0;
      else if (xfer)   cnt <= cnt + 10'd1;

      // Without a gamma unit, bytes are still consumed so the host never
      // stalls, but nothing is written and the table never becomes valid.
      gamma_wr <= xfer & present;
      if (xfer) begin
        wr_addr  <= cnt;
        wr_value <= din;
      end

      if (load_start)            table_valid <= 1'b0;
      else if (last && present)  table_valid <= 1'b1;

      // A load start makes the table partially stale, so drop the enable now
      // rather than waiting for the next frame boundary.
      if (load_start || !present) gamma_en <= 1'b0;
      else if (vbl_rise)          gamma_en <= gamma_en_req & table_valid;
    end
  end

endmodule
